// File: rtl/regbank_bist_pkg.sv
// rtl/regbank_bist_pkg.sv - shared constants, state encoding and pattern function for regbank_bist
//
// Contents:
//   NREG, AW, DW, PAT_MUL  sweep geometry and pattern multiplier
//   state_t                sweep sequencer states
//   pat(k, inv)            expected register content: (k*PAT_MUL) mod 2^DW, optionally inverted
package regbank_bist_pkg;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int PAT_MUL = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] k, input logic inv);
    logic [DW-1:0] p;
    p = DW'(k) * DW'(PAT_MUL);
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/regbank_bist_if.sv
// rtl/regbank_bist_if.sv - register-file pin bundle between regbank_bist and regbank_v4
//
// Signals:
//   sr1, sr2         read addresses (BIST -> regfile)
//   dr               write address  (BIST -> regfile)
//   wrData           write data     (BIST -> regfile)
//   write            write enable   (BIST -> regfile)
//   rdData1, rdData2 read data, combinational from sr1/sr2 (regfile -> BIST)
// Modports: master = BIST side, slave = register file side.
interface regbank_bist_if;
  import regbank_bist_pkg::*;

  logic [AW-1:0] sr1;
  logic [AW-1:0] sr2;
  logic [AW-1:0] dr;
  logic [DW-1:0] wrData;
  logic          write;
  logic [DW-1:0] rdData1;
  logic [DW-1:0] rdData2;

  modport master (
    output sr1, sr2, dr, wrData, write,
    input  rdData1, rdData2
  );

  modport slave (
    input  sr1, sr2, dr, wrData, write,
    output rdData1, rdData2
  );

endinterface

// File: rtl/regbank_bist_cmp.sv
// rtl/regbank_bist_cmp.sv - dual read-data comparator, saturating error count, first-error latch
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   clear                zero the accumulated results (accepted start)
//   valid                addr1/addr2 hold a pair whose read data is on rd1/rd2 this cycle
//   inv                  compare against the inverted pattern
//   addr1, addr2         addresses currently presented on sr1/sr2
//   rd1, rd2             register read data
//   err_count            mismatching reads, saturating at 127
//   first_err_addr       address of the first mismatch, 0 if none
module regbank_bist_cmp
  import regbank_bist_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          valid,
  input  logic          inv,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [6:0]    err_count,
  output logic [AW-1:0] first_err_addr
);

  logic       miss1;
  logic       miss2;
  logic [7:0] sum;

  always_comb begin
    miss1 = valid && (rd1 != pat(addr1, inv));
    miss2 = valid && (rd2 != pat(addr2, inv));
    sum   = {1'b0, err_count} + {7'd0, miss1} + {7'd0, miss2};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      // sum tops out at 129, so bit 7 set means the 7-bit count overflowed
      err_count <= sum[7] ? 7'd127 : sum[6:0];
      // a zero count means nothing has been latched yet; the count never returns to zero
      // without a clear, so only the first mismatching cycle loads the address
      if (err_count == 7'd0 && (miss1 || miss2))
        first_err_addr <= miss1 ? addr1 : addr2;
    end
  end

endmodule

// File: rtl/regbank_bist.sv
// rtl/regbank_bist.sv - write/readback self-test initiator for the regbank_v4 register file
//
// Ports:
//   clk             clock
//   reset           asynchronous active-low reset
//   start           1-cycle request, honoured only in IDLE/DONE
//   busy            sweep in progress (WRITE/READ/FLUSH)
//   done            sticky end-of-test, high only in DONE
//   pass            done with zero errors
//   err_count       mismatching register reads, saturating at 127
//   first_err_addr  first mismatching address, 0 if none
//   rb              register-file pins (master side of regbank_bist_if)
// Optional feature: REGBANK_BIST_INV_PASS_EN adds a second sweep with the inverted pattern.
module regbank_bist
  import regbank_bist_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [6:0]     err_count,
  output logic [AW-1:0]  first_err_addr,
  regbank_bist_if.master rb
);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          inv_q, inv_d;
  logic          clr;

  // Read pipeline: the pair addressed by cnt in READ is registered here and driven onto
  // sr1/sr2, so the combinational read data and the compare addresses stay aligned.
  logic [AW-1:0] rd_addr1_q;
  logic [AW-1:0] rd_addr2_q;
  logic          rd_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      if (state_q == READ) begin
        rd_addr1_q <= {cnt_q[AW-2:0], 1'b0};
        rd_addr2_q <= {cnt_q[AW-2:0], 1'b1};
        rd_valid_q <= 1'b1;
      end else begin
        rd_addr1_q <= '0;
        rd_addr2_q <= '0;
        rd_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WRITE;
          cnt_d   = '0;
          inv_d   = 1'b0;
          clr     = 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ: begin
        if (cnt_q == AW'(NREG / 2 - 1)) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
`ifdef REGBANK_BIST_INV_PASS_EN
        if (!inv_q) begin
          state_d = WRITE;
          cnt_d   = '0;
          inv_d   = 1'b1;
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-port drive is decoded from the state register so reset forces it low at once
  always_comb begin
    rb.write  = (state_q == WRITE);
    rb.dr     = rb.write ? cnt_q : '0;
    rb.wrData = rb.write ? pat(cnt_q, inv_q) : '0;
    rb.sr1    = rd_addr1_q;
    rb.sr2    = rd_addr2_q;
  end

  regbank_bist_cmp u_cmp (
    .clk            (clk),
    .reset          (reset),
    .clear          (clr),
    .valid          (rd_valid_q),
    .inv            (inv_q),
    .addr1          (rd_addr1_q),
    .addr2          (rd_addr2_q),
    .rd1            (rb.rdData1),
    .rd2            (rb.rdData2),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always_comb begin
    busy = (state_q == WRITE) || (state_q == READ) || (state_q == FLUSH);
    done = (state_q == DONE);
    pass = done && (err_count == 7'd0);
  end

endmodule

// File: tb/tb_regbank_bist.sv
// tb/tb_regbank_bist.sv - self-checking bench for regbank_bist with a fault-injectable register file
module tb_regbank_bist;

`ifdef REGBANK_BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int LAT = NPASS * (32 + 16 + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [6:0]  err_count;
  logic [4:0]  first_err_addr;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;

  logic [31:0] mem [32];
  logic [31:0] sa1 [32];
  logic [31:0] sa0 [32];

  regbank_bist_if bus ();

  regbank_bist dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .rb             (bus)
  );

  always #5 clk = ~clk;

  // Register file stand-in: synchronous write, combinational read with stuck-at overlays
  assign bus.rdData1 = (mem[bus.sr1] | sa1[bus.sr1]) & ~sa0[bus.sr1];
  assign bus.rdData2 = (mem[bus.sr2] | sa1[bus.sr2]) & ~sa0[bus.sr2];

  always @(posedge clk) begin
    if (bus.write) begin
      mem[bus.dr] <= bus.wrData;
      wr_count = wr_count + 1;
    end
  end

  task automatic clear_faults();
    for (int i = 0; i < 32; i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  // Expected outcome from the fault map: every register is written then read once per pass,
  // reads visited in ascending address order.
  task automatic model_run(output int e_err, output int e_first);
    int cnt;
    int first;
    logic [31:0] w;
    logic [31:0] r;
    cnt = 0;
    first = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int k = 0; k < 32; k++) begin
        w = 32'(k * 10);
        if (p == 1) w = ~w;
        r = (w | sa1[k]) & ~sa0[k];
        if (r !== w) begin
          if (cnt == 0) first = k;
          cnt++;
        end
      end
    end
    e_err = (cnt > 127) ? 127 : cnt;
    e_first = first;
  endtask

  // Pulse start, then count edges until done; glitch_edge>0 re-asserts start for that edge
  task automatic run_sweep(input int glitch_edge, output int lat, output logic busy0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (lat < 400) begin
      start = (lat + 1 == glitch_edge);
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input int glitch_edge);
    int lat;
    int e_err;
    int e_first;
    logic busy0;
    model_run(e_err, e_first);
    run_sweep(glitch_edge, lat, busy0);
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start got %b want 1", name, busy0);
    end
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL %s latency got %0d want %0d", name, lat, LAT);
    end
    vectors++;
    if (err_count !== 7'(e_err)) begin
      miscompares++;
      $display("FAIL %s err_count got %0d want %0d", name, err_count, e_err);
    end
    vectors++;
    if (first_err_addr !== 5'(e_first)) begin
      miscompares++;
      $display("FAIL %s first_err_addr got %0d want %0d", name, first_err_addr, e_first);
    end
    vectors++;
    if (pass !== (e_err == 0)) begin
      miscompares++;
      $display("FAIL %s pass got %b want %b", name, pass, (e_err == 0));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, pass, err_count, first_err_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_status got %b want 0", {busy, done, pass, err_count, first_err_addr});
    end
    vectors++;
    if ({bus.write, bus.dr, bus.wrData, bus.sr1, bus.sr2} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus got %h want 0", {bus.write, bus.dr, bus.wrData, bus.sr1, bus.sr2});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_good_sweep();
    logic [31:0] w;
    clear_faults();
    wr_count = 0;
    check_run("good", 0);
    vectors++;
    if (wr_count !== 32 * NPASS) begin
      miscompares++;
      $display("FAIL good_write_count got %0d want %0d", wr_count, 32 * NPASS);
    end
    for (int k = 0; k < 32; k++) begin
      w = 32'(k * 10);
      if (NPASS == 2) w = ~w;
      vectors++;
      if (mem[k] !== w) begin
        miscompares++;
        $display("FAIL readback reg%0d got %h want %h", k, mem[k], w);
      end
    end
  endtask

  task automatic test_stuck_single();
    clear_faults();
    sa1[7] = 32'h1;
    check_run("stuck_reg7", 0);
    vectors++;
    if (err_count !== 7'd1 || first_err_addr !== 5'd7) begin
      miscompares++;
      $display("FAIL stuck_reg7_fixed got %0d/%0d want 1/7", err_count, first_err_addr);
    end
  endtask

  task automatic test_same_cycle();
    clear_faults();
    sa1[4] = 32'h1;
    sa0[5] = 32'h2;
    check_run("pair_4_5", 0);
    vectors++;
    if (first_err_addr !== 5'd4) begin
      miscompares++;
      $display("FAIL pair_4_5_first got %0d want 4", first_err_addr);
    end
  endtask

  task automatic test_random_faults();
    int nf;
    int r;
    for (int it = 0; it < 8; it++) begin
      clear_faults();
      nf = $urandom_range(1, 5);
      for (int f = 0; f < nf; f++) begin
        r = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) sa1[r] = sa1[r] | (32'h1 << $urandom_range(0, 31));
        else sa0[r] = sa0[r] | (32'h1 << $urandom_range(0, 31));
      end
      check_run($sformatf("random%0d", it), 0);
    end
  endtask

  task automatic test_start_while_busy();
    clear_faults();
    wr_count = 0;
    check_run("start_busy", 10);
    vectors++;
    if (wr_count !== 32 * NPASS) begin
      miscompares++;
      $display("FAIL start_busy_write_count got %0d want %0d", wr_count, 32 * NPASS);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (bus.write !== 1'b1 || bus.dr !== 5'd10) begin
      miscompares++;
      $display("FAIL midreset_pre got write=%b dr=%0d want 1/10", bus.write, bus.dr);
    end
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus.write, busy, bus.dr} !== '0) begin
      miscompares++;
      $display("FAIL midreset_drop got %b want 0", {bus.write, busy, bus.dr});
    end
    @(negedge clk);
    reset = 1'b1;
    clear_faults();
    check_run("after_midreset", 0);
  endtask

  task automatic test_restart_from_done();
    int lat;
    clear_faults();
    sa1[3] = 32'h1;
    check_run("restart_fail", 0);
    clear_faults();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if ({done, pass, err_count, first_err_addr} !== '0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear got busy=%b done=%b pass=%b err=%0d first=%0d want 1/0/0/0/0",
               busy, done, pass, err_count, first_err_addr);
    end
    lat = 0;
    while (lat < 400 && !done) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vectors++;
    if (pass !== 1'b1 || err_count !== 7'd0 || lat !== LAT) begin
      miscompares++;
      $display("FAIL restart_pass got pass=%b err=%0d lat=%0d want 1/0/%0d", pass, err_count, lat, LAT);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    clear_faults();
    test_reset();
    test_good_sweep();
    test_stuck_single();
    test_same_cycle();
    test_random_faults();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_restart_from_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
